// File: rtl/decode_issue_ctrl.sv
// Single-slot decode/issue control for a MIPS-style pipeline: holds one instruction,
// detects load-use and HI/LO hazards, inserts bubbles and counts stall cycles.
module decode_issue_ctrl #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic        id_bubble,
  output logic        mdu_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_reg_q, pend_reg_d;
  logic [4:0]  mdu_cnt_q, mdu_cnt_d;
  logic [15:0] stall_q, stall_d;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt;
  logic       is_load, is_mult, is_div, hilo_user;
  logic       slot_live, load_hazard, mdu_hazard, hazard, issue, transfer;

  assign opcode = slot_instr_q[31:26];
  assign rs     = slot_instr_q[25:21];
  assign rt     = slot_instr_q[20:16];
  assign funct  = slot_instr_q[5:0];

  always_comb begin
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
      6'h02, 6'h03:               uses_rs = 1'b0;
      default:                    ;
    endcase
  end

  assign is_load   = opcode inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_mult   = (opcode == 6'h00) && (funct inside {6'h18, 6'h19});
  assign is_div    = (opcode == 6'h00) && (funct inside {6'h1A, 6'h1B});
  assign hilo_user = (opcode == 6'h00) &&
                     (funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});

  // Outputs are forced quiet while reset is held, before the first reset edge lands.
  assign slot_live   = slot_valid_q & rst_n;
  assign load_hazard = pend_valid_q &
                       ((uses_rs && rs != 5'd0 && rs == pend_reg_q) ||
                        (uses_rt && rt != 5'd0 && rt == pend_reg_q));
  assign mdu_hazard  = (mdu_cnt_q != 5'd0) & hilo_user;
  assign hazard      = slot_live & (load_hazard | mdu_hazard);
  assign issue       = slot_live & ~hazard & ex_ready & ~flush;

  assign if_ready     = ~flush & (~slot_live | issue);
  assign transfer     = if_valid & if_ready;
  assign id_valid     = slot_live & ~hazard & ~flush;
  assign id_bubble    = slot_live & hazard & ~flush;
  assign id_instr     = slot_instr_q;
  assign mdu_busy     = (mdu_cnt_q != 5'd0) & rst_n;
  assign stall_cycles = stall_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    pend_valid_d = pend_valid_q;
    pend_reg_d   = pend_reg_q;
    mdu_cnt_d    = mdu_cnt_q;
    stall_d      = stall_q;

    if (flush) begin
      slot_valid_d = 1'b0;
    end else if (transfer) begin
      slot_valid_d = 1'b1;
      slot_instr_d = if_instr;
    end else if (issue) begin
      slot_valid_d = 1'b0;
    end

    // Scoreboard lives only one cycle past the load; a flush freezes it.
    if (!flush && ex_ready) begin
      if (issue && is_load && rt != 5'd0) begin
        pend_valid_d = 1'b1;
        pend_reg_d   = rt;
      end else begin
        pend_valid_d = 1'b0;
      end
    end

    if (issue && is_mult)       mdu_cnt_d = MULT_LOAD;
    else if (issue && is_div)   mdu_cnt_d = DIV_LOAD;
    else if (mdu_cnt_q != 5'd0) mdu_cnt_d = mdu_cnt_q - 5'd1;

    if (id_bubble && ex_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_q <= 1'b0;
      slot_instr_q <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= 5'd0;
      mdu_cnt_q    <= 5'd0;
      stall_q      <= 16'd0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      mdu_cnt_q    <= mdu_cnt_d;
      stall_q      <= stall_d;
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: streaming, load-use, HI/LO, flush,
// backpressure and mid-operation reset, each with hand-derived expectations.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, ex_ready, flush;
  logic [31:0] if_instr;
  logic        if_ready, id_valid, id_bubble, mdu_busy;
  logic [31:0] id_instr;
  logic [15:0] stall_cycles;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [31:0] ADDU_657 = 32'h00A7_3021; // addu $6,$5,$7
  localparam logic [31:0] ADDU_600 = 32'h0000_3021; // addu $6,$0,$0
  localparam logic [31:0] ADDU_678 = 32'h00E8_3021; // addu $6,$7,$8
  localparam logic [31:0] LW_5     = 32'h8C25_0000; // lw $5,0($1)
  localparam logic [31:0] LW_0     = 32'h8C20_0000; // lw $0,0($1)
  localparam logic [31:0] ORI      = 32'h3462_0001; // ori $2,$3,1
  localparam logic [31:0] JMP      = 32'h0800_0040; // j 0x100
  localparam logic [31:0] MULT     = 32'h0085_0018; // mult $4,$5
  localparam logic [31:0] MFLO     = 32'h0000_1012; // mflo $2
  localparam logic [31:0] DIV      = 32'h0085_001A; // div $4,$5

  always #5 clk = ~clk;

  decode_issue_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush),
    .id_valid(id_valid), .id_instr(id_instr), .id_bubble(id_bubble),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] ins);
    if_valid = v;
    if_instr = ins;
    settle();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b1; flush = 1'b0;
    tick(); tick();
    settle();
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b expected 0", id_valid); else pass_cnt++;
    total_cnt++; if (id_bubble !== 1'b0) $display("FAIL reset_id_bubble: got %b expected 0", id_bubble); else pass_cnt++;
    total_cnt++; if (mdu_busy !== 1'b0) $display("FAIL reset_mdu_busy: got %b expected 0", mdu_busy); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL reset_if_ready: got %b expected 1", if_ready); else pass_cnt++;
    total_cnt++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cycles); else pass_cnt++;
    rst_n = 1'b1;
    $display("reset: done");
  endtask

  task automatic test_streaming;
    present(1'b1, ADDU_657);
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL stream_empty: got %b expected 0", id_valid); else pass_cnt++;
    tick();
    present(1'b1, ORI);
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== ADDU_657) $display("FAIL stream_addu: got v=%b %h expected v=1 %h", id_valid, id_instr, ADDU_657); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b1) $display("FAIL stream_if_ready: got %b expected 1", if_ready); else pass_cnt++;
    tick();
    present(1'b1, JMP);
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== ORI) $display("FAIL stream_ori: got v=%b %h expected v=1 %h", id_valid, id_instr, ORI); else pass_cnt++;
    tick();
    present(1'b0, '0);
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== JMP || id_bubble !== 1'b0) $display("FAIL stream_j: got v=%b b=%b %h expected v=1 b=0 %h", id_valid, id_bubble, id_instr, JMP); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (id_valid !== 1'b0 || stall_cycles !== 16'd0) $display("FAIL stream_end: got v=%b stall=%0d expected v=0 stall=0", id_valid, stall_cycles); else pass_cnt++;
    $display("streaming: addu/ori/j issued back-to-back");
  endtask

  task automatic test_load_use;
    present(1'b1, LW_5);
    tick();
    present(1'b1, ADDU_657);
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== LW_5) $display("FAIL lu_lw_issue: got v=%b %h expected v=1 %h", id_valid, id_instr, LW_5); else pass_cnt++;
    tick();
    present(1'b0, '0);
    total_cnt++; if (id_bubble !== 1'b1 || id_valid !== 1'b0) $display("FAIL lu_bubble: got b=%b v=%b expected b=1 v=0", id_bubble, id_valid); else pass_cnt++;
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL lu_if_ready: got %b expected 0", if_ready); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (id_valid !== 1'b1 || id_bubble !== 1'b0 || id_instr !== ADDU_657) $display("FAIL lu_issue: got v=%b b=%b %h expected v=1 b=0 %h", id_valid, id_bubble, id_instr, ADDU_657); else pass_cnt++;
    total_cnt++; if (stall_cycles !== 16'd1) $display("FAIL lu_stall: got %0d expected 1", stall_cycles); else pass_cnt++;
    tick();
    $display("load_use: lw $5 / addu $6,$5,$7 one bubble");
  endtask

  task automatic test_no_hazard;
    present(1'b1, LW_0);
    tick();
    present(1'b1, ADDU_600);
    tick();
    present(1'b0, '0);
    total_cnt++; if (id_valid !== 1'b1 || id_bubble !== 1'b0) $display("FAIL nh_zero_reg: got v=%b b=%b expected v=1 b=0", id_valid, id_bubble); else pass_cnt++;
    tick();
    present(1'b1, LW_5);
    tick();
    present(1'b1, ADDU_678);
    tick();
    present(1'b0, '0);
    total_cnt++; if (id_valid !== 1'b1 || id_bubble !== 1'b0 || id_instr !== ADDU_678) $display("FAIL nh_indep: got v=%b b=%b %h expected v=1 b=0 %h", id_valid, id_bubble, id_instr, ADDU_678); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (stall_cycles !== 16'd1) $display("FAIL nh_stall: got %0d expected 1", stall_cycles); else pass_cnt++;
    $display("no_hazard: $0 and independent sources issue without bubble");
  endtask

  task automatic test_mdu;
    present(1'b1, MULT);
    tick();
    present(1'b1, MFLO);
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== MULT) $display("FAIL mdu_mult_issue: got v=%b %h expected v=1 %h", id_valid, id_instr, MULT); else pass_cnt++;
    tick();
    present(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (id_bubble !== 1'b1 || mdu_busy !== 1'b1) $display("FAIL mdu_mflo_bubble%0d: got b=%b busy=%b expected b=1 busy=1", i, id_bubble, mdu_busy); else pass_cnt++;
      tick();
    end
    total_cnt++; if (id_valid !== 1'b1 || mdu_busy !== 1'b0 || id_instr !== MFLO) $display("FAIL mdu_mflo_issue: got v=%b busy=%b %h expected v=1 busy=0 %h", id_valid, mdu_busy, id_instr, MFLO); else pass_cnt++;
    total_cnt++; if (stall_cycles !== 16'd5) $display("FAIL mdu_mult_stall: got %0d expected 5", stall_cycles); else pass_cnt++;
    tick();
    present(1'b1, DIV);
    tick();
    present(1'b1, DIV);
    tick();
    present(1'b0, '0);
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (id_bubble !== 1'b1) $display("FAIL mdu_div_bubble%0d: got %b expected 1", i, id_bubble); else pass_cnt++;
      tick();
    end
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== DIV) $display("FAIL mdu_div_issue: got v=%b %h expected v=1 %h", id_valid, id_instr, DIV); else pass_cnt++;
    total_cnt++; if (stall_cycles !== 16'd21) $display("FAIL mdu_div_stall: got %0d expected 21", stall_cycles); else pass_cnt++;
    tick();
    $display("mdu: mult/mflo 4 bubbles, div/div 16 bubbles");
  endtask

  task automatic test_reset_mid_div;
    tick(); tick(); tick();
    total_cnt++; if (mdu_busy !== 1'b1) $display("FAIL rst_div_busy_before: got %b expected 1", mdu_busy); else pass_cnt++;
    rst_n = 1'b0;
    settle();
    total_cnt++; if (mdu_busy !== 1'b0) $display("FAIL rst_div_busy_during: got %b expected 0", mdu_busy); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    settle();
    total_cnt++; if (mdu_busy !== 1'b0 || stall_cycles !== 16'd0) $display("FAIL rst_div_after: got busy=%b stall=%0d expected busy=0 stall=0", mdu_busy, stall_cycles); else pass_cnt++;
    total_cnt++; if (id_valid !== 1'b0 || if_ready !== 1'b1) $display("FAIL rst_div_slot: got v=%b rdy=%b expected v=0 rdy=1", id_valid, if_ready); else pass_cnt++;
    $display("reset_mid_div: state cleared");
  endtask

  task automatic test_flush;
    present(1'b1, LW_5);
    tick();
    present(1'b1, ADDU_657);
    tick();
    flush = 1'b1;
    present(1'b1, ORI);
    total_cnt++; if (if_ready !== 1'b0) $display("FAIL fl_if_ready: got %b expected 0", if_ready); else pass_cnt++;
    total_cnt++; if (id_bubble !== 1'b0 || id_valid !== 1'b0) $display("FAIL fl_outputs: got b=%b v=%b expected b=0 v=0", id_bubble, id_valid); else pass_cnt++;
    tick();
    flush = 1'b0;
    ex_ready = 1'b0;
    present(1'b1, ADDU_657);
    total_cnt++; if (id_valid !== 1'b0 || id_bubble !== 1'b0 || if_ready !== 1'b1) $display("FAIL fl_slot_empty: got v=%b b=%b rdy=%b expected v=0 b=0 rdy=1", id_valid, id_bubble, if_ready); else pass_cnt++;
    total_cnt++; if (stall_cycles !== 16'd0) $display("FAIL fl_stall: got %0d expected 0", stall_cycles); else pass_cnt++;
    tick();
    ex_ready = 1'b1;
    present(1'b0, '0);
    total_cnt++; if (id_bubble !== 1'b1) $display("FAIL fl_pend_kept: got %b expected 1", id_bubble); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (id_valid !== 1'b1 || stall_cycles !== 16'd1) $display("FAIL fl_reissue: got v=%b stall=%0d expected v=1 stall=1", id_valid, stall_cycles); else pass_cnt++;
    tick();
    $display("flush: slot killed, load-use scoreboard retained");
  endtask

  task automatic test_backpressure;
    present(1'b1, LW_5);
    tick();
    present(1'b1, ADDU_657);
    tick();
    present(1'b0, '0);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total_cnt++; if (id_bubble !== 1'b1 || stall_cycles !== 16'd1) $display("FAIL bp_frozen%0d: got b=%b stall=%0d expected b=1 stall=1", i, id_bubble, stall_cycles); else pass_cnt++;
      tick();
    end
    ex_ready = 1'b1;
    settle();
    total_cnt++; if (id_bubble !== 1'b1) $display("FAIL bp_bubble_resume: got %b expected 1", id_bubble); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (id_valid !== 1'b1 || stall_cycles !== 16'd2) $display("FAIL bp_issue: got v=%b stall=%0d expected v=1 stall=2", id_valid, stall_cycles); else pass_cnt++;
    tick();
    $display("backpressure: stall count frozen while ex_ready low");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_load_use();
    test_no_hazard();
    test_mdu();
    test_reset_mid_div();
    test_flush();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
